imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side master for the 32-word instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles 32-bit instruction words little-endian and issues one write per word into the instruction memory write port (write enable, address, write data).
- Holds the CPU in stall while loading and releases it when the programmed word count has been written.

Parameters:
- ADDR_WIDTH, 5, instruction memory address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- BYTES_PER_WORD, DATA_WIDTH/8, derived; bytes per word; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load session.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- im_we  output  1  instruction memory write enable.
- im_addr  output  ADDR_WIDTH  instruction memory write address.
- im_wdata  output  DATA_WIDTH  instruction memory write data.
- cpu_hold  output  1  CPU stall; high from start until load completes.
- load_done  output  1  high after a completed session; cleared by start or reset.
- load_error  output  1  checksum failure flag (CHECKSUM_EN only; otherwise tied 0).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - byte_ready, im_we, cpu_hold, load_done and load_error = 0.
  - im_addr = 0, im_wdata = 0.
  - Internal byte counter, word counter and word count = 0.
- Handshake:
  - A byte transfers only in a cycle where byte_valid and byte_ready are both high.
  - byte_ready is registered. It is high only in COUNT, ASSEMBLE and CHECK.
  - byte_data is ignored whenever byte_ready is low.
- IDLE:
  - cpu_hold = 0.
  - start → COUNT; the same edge clears load_done and load_error and sets cpu_hold = 1.
- COUNT:
  - The first accepted byte is the word count N. The low ADDR_WIDTH+1 bits are used.
  - N = 0 or N > 2^ADDR_WIDTH is treated as full depth (32 words).
  - Word counter is reset to 0. Next state is ASSEMBLE.
- ASSEMBLE:
  - Accepted bytes fill the word LSB first: byte k goes to bits [8k+7:8k].
  - After the BYTES_PER_WORD-th byte, the next state is WRITE.
- WRITE (exactly one cycle):
  - im_we = 1, im_addr = word counter, im_wdata = assembled word.
  - byte_ready = 0.
  - Word counter increments.
  - If this was word N-1, the next state is DONE (or CHECK when CHECKSUM_EN). Otherwise the next state is ASSEMBLE.
  - im_we is never high outside WRITE.
- DONE:
  - load_done = 1 and cpu_hold = 0, both in the cycle after the last im_we.
  - Next state is IDLE; load_done stays high until the next start or reset.
- Latency: the last data byte is accepted at edge t; im_we is high in cycle t+1; cpu_hold falls at edge t+2.
- Boundary conditions:
  - Address is at most 31 and never wraps within a session.
  - start outside IDLE is ignored.
  - byte_valid with no session active has no effect.
  - Source stalls (byte_valid low) hold state indefinitely; there is no timeout.
  - Reset mid-session aborts immediately. Partially loaded words stay in memory. cpu_hold drops and load_done = 0.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers all data bytes; the count byte is excluded.
  - After the last WRITE, the state is CHECK, with one more byte accepted.
  - Mismatch sets load_error = 1 in DONE; load_done is still asserted and the memory contents are kept.
  - The XOR accumulator is cleared on start.
- Undefined:
  - No CHECK state and no accumulator.
  - load_error is constant 0; the FSM goes WRITE → DONE directly.

Test Plan:
- Reset then idle: rst_n low, then high, no start → all outputs 0, byte_ready 0 for 20 cycles despite byte_valid = 1.
- Single word: start; bytes 01, 78, 56, 34, 12 → exactly one im_we pulse with im_addr = 0 and im_wdata = 0x12345678; load_done = 1 and cpu_hold = 0 two cycles after the last byte.
- Full depth: start, count byte 00, 128 bytes where word i = i*0x01010101 → 32 writes at addresses 0..31 with matching data, no write beyond 31, load_done = 1.
- Backpressure and stalls: randomly deassert byte_valid during a 3-word load → same three writes, in order; byte_ready low in every im_we cycle; no byte lost or duplicated.
- Reset mid-load: rst_n low after 2 of 4 bytes of word 1 → no further im_we, cpu_hold = 0 and load_done = 0 immediately; a new start then loads normally from address 0.
- CHECKSUM_EN: load 1 word AA BB CC DD, then checksum 00 → load_error = 0; repeat with checksum 01 → load_error = 1 and load_done = 1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: assembles little-endian words, writes them, stalls the CPU meanwhile.
// Optional CHECKSUM_EN macro adds a trailing XOR checksum byte and the load_error flag.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    ASSEMBLE,
    WRITE,
`ifdef CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      byte_idx;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      word_total;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [DATA_WIDTH-1:0] word_next;
  logic [CNT_W-1:0]      count_field;
  logic [CNT_W-1:0]      count_decoded;
  logic                  accept;
  logic                  last_byte;
  logic                  last_word;

  assign accept      = byte_valid && byte_ready;
  assign last_byte   = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign last_word   = (word_cnt == (word_total - CNT_W'(1)));
  assign count_field = byte_data[CNT_W-1:0];

  // Zero or an over-range count both mean a full-depth load.
  always_comb begin
    count_decoded = count_field;
    if (count_field == '0 || count_field > CNT_W'(DEPTH))
      count_decoded = CNT_W'(DEPTH);
  end

  always_comb begin
    word_next = word_buf;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (byte_idx == IDX_W'(k))
        word_next[8*k +: 8] = byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start) state_next = COUNT;
      COUNT:    if (accept) state_next = ASSEMBLE;
      ASSEMBLE: if (accept && last_byte) state_next = WRITE;
      WRITE: begin
        if (!last_word)
          state_next = ASSEMBLE;
        else
`ifdef CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
      end
`ifdef CHECKSUM_EN
      CHECK:    if (accept) state_next = DONE;
`endif
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Handshake and write strobe are registered from the next-state decode,
  // so they track the state register exactly without a combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
    end else begin
      byte_ready <= (state_next == COUNT) || (state_next == ASSEMBLE)
`ifdef CHECKSUM_EN
                    || (state_next == CHECK)
`endif
                    ;
      im_we      <= (state_next == WRITE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      word_buf   <= '0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            load_done <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end
        COUNT: begin
          if (accept) begin
            word_total <= count_decoded;
            word_cnt   <= '0;
            byte_idx   <= '0;
          end
        end
        ASSEMBLE: begin
          if (accept) begin
            word_buf <= word_next;
            if (last_byte) begin
              byte_idx <= '0;
              im_addr  <= word_cnt[ADDR_WIDTH-1:0];
              im_wdata <= word_next;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        WRITE: word_cnt <= word_cnt + CNT_W'(1);
        DONE: begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] xor_acc;
  logic       chk_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_acc    <= '0;
      chk_bad    <= 1'b0;
      load_error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        xor_acc    <= '0;
        chk_bad    <= 1'b0;
        load_error <= 1'b0;
      end
      if (state == ASSEMBLE && accept)
        xor_acc <= xor_acc ^ byte_data;
      if (state == CHECK && accept)
        chk_bad <= (byte_data != xor_acc);
      if (state == DONE)
        load_error <= chk_bad;
    end
  end
`else
  assign load_error = 1'b0;
`endif

endmodule
